touch_adc_spi_controller: RTL and testbench



---
 rtl/touch_adc_pkg.sv | 26 ++
 rtl/touch_adc_spi_controller_if.sv | 26 ++
 rtl/touch_adc_spi_frame.sv | 99 +++++++++
 rtl/touch_adc_spi_controller.sv | 188 ++++++++++++++++++
 tb/tb_touch_adc_spi_controller.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/touch_adc_pkg.sv
// ============================================================================
// Module : touch_adc_pkg
// Brief  : Shared constants and FSM state type for the touch-panel ADC block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package touch_adc_pkg;

  localparam logic [7:0] CMD_X         = 8'h92;
  localparam logic [7:0] CMD_Y         = 8'hD2;
  localparam int         FRAME_PERIODS = 24;
  localparam int         DATA_FIRST    = 9;
  localparam int         DATA_BITS     = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FRAME_X = 3'd1,
    INTER   = 3'd2,
    FRAME_Y = 3'd3,
    GAP     = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/touch_adc_spi_controller_if.sv
// ============================================================================
// Module : touch_adc_spi_controller_if
// Brief  : Pin bundle between the controller and the AD7843-class touch ADC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface touch_adc_spi_controller_if;
  logic ADC_CS_N;
  logic ADC_DCLK;
  logic ADC_DIN;
  logic ADC_DOUT;
  logic PENIRQ_N;

  modport master (
    output ADC_CS_N, ADC_DCLK, ADC_DIN,
    input  ADC_DOUT, PENIRQ_N
  );

  modport slave (
    input  ADC_CS_N, ADC_DCLK, ADC_DIN,
    output ADC_DOUT, PENIRQ_N
  );
endinterface

`default_nettype wire

// File: rtl/touch_adc_spi_frame.sv
// ============================================================================
// Module : touch_adc_spi_frame
// Brief  : One 24-DCLK conversion frame: setup half, 48 clock halves, hold half.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module touch_adc_spi_frame
  import touch_adc_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  wire logic                 Clock,
  input  wire logic                 Reset,
  input  wire logic                 i_start,
  input  wire logic [7:0]           i_cmd,
  input  wire logic                 i_dout,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [DATA_BITS-1:0]      o_result,
  output logic                      o_cs_n,
  output logic                      o_dclk,
  output logic                      o_din
);

  localparam int              CW          = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   C_CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [5:0]      C_HALF_LAST = 6'(2 * FRAME_PERIODS + 1);
  localparam logic [5:0]      C_CMD_END   = 6'd8;
  localparam logic [5:0]      C_DATA_LO   = 6'(DATA_FIRST);
  localparam logic [5:0]      C_DATA_HI   = 6'(DATA_FIRST + DATA_BITS - 1);

  logic                 r_busy, r_done, r_cs_n, r_dclk, r_din;
  logic [CW-1:0]        r_cnt;
  logic [5:0]           r_half;
  logic [7:0]           r_cmd;
  logic [DATA_BITS-1:0] r_shift, r_result;
  logic [5:0]           w_next_half, w_period;

  // Half 0 is setup; odd halves are the low phase of period (h-1)/2, even the high phase.
  assign w_next_half = r_half + 6'd1;
  assign w_period    = {1'b0, w_next_half[5:1]} - {5'd0, ~w_next_half[0]};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_dclk   <= 1'b0;
      r_din    <= 1'b0;
      r_cnt    <= '0;
      r_half   <= '0;
      r_cmd    <= '0;
      r_shift  <= '0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy <= 1'b1;
          r_cs_n <= 1'b0;
          r_dclk <= 1'b0;
          r_din  <= 1'b0;
          r_cnt  <= '0;
          r_half <= '0;
          r_cmd  <= i_cmd;
        end
      end else if (r_cnt == C_CNT_LAST) begin
        r_cnt <= '0;
        if (r_half == C_HALF_LAST) begin
          r_busy   <= 1'b0;
          r_cs_n   <= 1'b1;
          r_done   <= 1'b1;
          r_result <= r_shift;
        end else begin
          r_half <= w_next_half;
          r_dclk <= ~w_next_half[0];
          if (w_next_half[0]) begin
            r_din <= (w_period < C_CMD_END) ? r_cmd[~w_period[2:0]] : 1'b0;
          end else if (w_period >= C_DATA_LO && w_period <= C_DATA_HI) begin
            r_shift <= {r_shift[DATA_BITS-2:0], i_dout};
          end
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_cs_n   = r_cs_n;
  assign o_dclk   = r_dclk;
  assign o_din    = r_din;

endmodule

`default_nettype wire

// File: rtl/touch_adc_spi_controller.sv
// ============================================================================
// Module : touch_adc_spi_controller
// Brief  : Pen debounce and X/Y conversion sequencing for the LTM touch panel.
//          Optional two-sample averaging per axis: define TOUCH_AVERAGE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module touch_adc_spi_controller
  import touch_adc_pkg::*;
#(
  parameter int CLK_DIV      = 16,
  parameter int PEN_DEBOUNCE = 1000,
  parameter int SAMPLE_GAP   = 2000
) (
  input  wire logic                   Clock,
  input  wire logic                   Reset,
  touch_adc_spi_controller_if.master  adc,
  output logic                        Touch_En,
  output logic                        Coord_En,
  output logic [11:0]                 X_Coord,
  output logic [11:0]                 Y_Coord
);

  localparam logic [31:0] C_DEB_LAST   = 32'(PEN_DEBOUNCE - 1);
  localparam logic [31:0] C_INTER_LAST = 32'(CLK_DIV - 1);
  localparam logic [31:0] C_GAP_LAST   = 32'(SAMPLE_GAP - 1);

  logic [1:0]           r_pen_sync, r_dout_sync;
  state_t               r_state;
  logic [31:0]          r_cnt;
  logic                 r_start;
  logic [7:0]           r_cmd;
  logic [11:0]          r_pend_x, r_pend_y, r_x, r_y;
  logic                 r_touch_en, r_coord_en;
  logic                 w_busy, w_done, w_cs_n, w_dclk, w_din, w_pen_low;
  logic [DATA_BITS-1:0] w_result;

`ifdef TOUCH_AVERAGE_EN
  logic                 r_second, r_next_x;
  logic [11:0]          r_s0;
  logic [12:0]          w_sum;
  assign w_sum = {1'b0, r_s0} + {1'b0, w_result};
`endif

  touch_adc_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .Clock    (Clock),
    .Reset    (Reset),
    .i_start  (r_start),
    .i_cmd    (r_cmd),
    .i_dout   (r_dout_sync[1]),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_result (w_result),
    .o_cs_n   (w_cs_n),
    .o_dclk   (w_dclk),
    .o_din    (w_din)
  );

  // PENIRQ_N is disturbed by conversions, so it only counts while CS_N is high.
  assign w_pen_low = ~r_pen_sync[1] & ~w_busy;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pen_sync  <= 2'b11;
      r_dout_sync <= 2'b00;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_start     <= 1'b0;
      r_cmd       <= '0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_touch_en  <= 1'b0;
      r_coord_en  <= 1'b0;
`ifdef TOUCH_AVERAGE_EN
      r_second    <= 1'b0;
      r_next_x    <= 1'b0;
      r_s0        <= '0;
`endif
    end else begin
      r_pen_sync  <= {r_pen_sync[0], adc.PENIRQ_N};
      r_dout_sync <= {r_dout_sync[0], adc.ADC_DOUT};
      r_start     <= 1'b0;
      r_coord_en  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_pen_low) begin
            r_cnt <= '0;
          end else if (r_cnt == C_DEB_LAST) begin
            r_cnt      <= '0;
            r_touch_en <= 1'b1;
            r_start    <= 1'b1;
            r_cmd      <= CMD_X;
            r_state    <= FRAME_X;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FRAME_X: begin
          if (w_done) begin
            r_cnt   <= '0;
            r_state <= INTER;
`ifdef TOUCH_AVERAGE_EN
            if (!r_second) begin
              r_s0     <= w_result;
              r_second <= 1'b1;
              r_next_x <= 1'b1;
            end else begin
              r_pend_x <= w_sum[12:1];
              r_second <= 1'b0;
              r_next_x <= 1'b0;
            end
`else
            r_pend_x <= w_result;
`endif
          end
        end
        INTER: begin
          if (r_cnt == C_INTER_LAST) begin
            r_cnt   <= '0;
            r_start <= 1'b1;
`ifdef TOUCH_AVERAGE_EN
            r_state <= r_next_x ? FRAME_X : FRAME_Y;
            r_cmd   <= r_next_x ? CMD_X : CMD_Y;
`else
            r_state <= FRAME_Y;
            r_cmd   <= CMD_Y;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FRAME_Y: begin
          if (w_done) begin
            r_cnt <= '0;
`ifdef TOUCH_AVERAGE_EN
            if (!r_second) begin
              r_s0     <= w_result;
              r_second <= 1'b1;
              r_next_x <= 1'b0;
              r_state  <= INTER;
            end else begin
              r_pend_y <= w_sum[12:1];
              r_second <= 1'b0;
              r_state  <= GAP;
            end
`else
            r_pend_y <= w_result;
            r_state  <= GAP;
`endif
          end
        end
        GAP: begin
          if (r_cnt == C_GAP_LAST) begin
            r_cnt <= '0;
            if (w_pen_low) begin
              r_x        <= r_pend_x;
              r_y        <= r_pend_y;
              r_coord_en <= 1'b1;
              r_start    <= 1'b1;
              r_cmd      <= CMD_X;
              r_state    <= FRAME_X;
            end else begin
              r_touch_en <= 1'b0;
              r_state    <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign adc.ADC_CS_N = w_cs_n;
  assign adc.ADC_DCLK = w_dclk;
  assign adc.ADC_DIN  = w_din;
  assign Touch_En     = r_touch_en;
  assign Coord_En     = r_coord_en;
  assign X_Coord      = r_x;
  assign Y_Coord      = r_y;

endmodule

`default_nettype wire

// File: tb/tb_touch_adc_spi_controller.sv
// ============================================================================
// Module : tb_touch_adc_spi_controller
// Brief  : Scoreboard bench with a behavioural AD7843 model for the touch controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_touch_adc_spi_controller;
  import touch_adc_pkg::*;

  localparam int C_CLK_DIV = 4;
  localparam int C_DEB     = 20;
  localparam int C_GAP     = 50;
  localparam int C_CS_LOW  = 50 * C_CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        touch_en, coord_en;
  logic [11:0] x_coord, y_coord;

  always #5 clk = ~clk;

  touch_adc_spi_controller_if adc_if ();

  touch_adc_spi_controller #(
    .CLK_DIV      (C_CLK_DIV),
    .PEN_DEBOUNCE (C_DEB),
    .SAMPLE_GAP   (C_GAP)
  ) dut (
    .Clock    (clk),
    .Reset    (rst),
    .adc      (adc_if),
    .Touch_En (touch_en),
    .Coord_En (coord_en),
    .X_Coord  (x_coord),
    .Y_Coord  (y_coord)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          cs_falls = 0;
  int          coord_cnt = 0;
  int          rises    = 0;
  int          width    = 0;
  bit          frame_chk = 1'b1;
  logic [7:0]  m_cmd    = '0;
  logic [11:0] m_sample = '0;
  logic        prev_cs  = 1'b1;
  logic        prev_dclk = 1'b0;
  logic [11:0] xq[$];
  logic [11:0] yq[$];
  logic [7:0]  cmd_q[$];
  logic [23:0] pair_q[$];
  int          strobe_t[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_frames(input logic [11:0] x0, input logic [11:0] x1,
                             input logic [11:0] y0, input logic [11:0] y1,
                             input bit exp_en, input logic [11:0] ex, input logic [11:0] ey);
    xq.push_back(x0);
    cmd_q.push_back(CMD_X);
`ifdef TOUCH_AVERAGE_EN
    xq.push_back(x1);
    cmd_q.push_back(CMD_X);
`endif
    yq.push_back(y0);
    cmd_q.push_back(CMD_Y);
`ifdef TOUCH_AVERAGE_EN
    yq.push_back(y1);
    cmd_q.push_back(CMD_Y);
`endif
    if (exp_en) pair_q.push_back({ex, ey});
  endtask

  task automatic wait_coord(input int n, input int budget);
    int k = 0;
    while (coord_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("coord_wait", 32'(coord_cnt >= n), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model and frame monitor: decodes DIN, returns queued samples on DOUT.
  initial begin
    adc_if.ADC_DOUT = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_cs && !adc_if.ADC_CS_N) begin
        rises = 0; width = 0; m_cmd = '0; m_sample = '0;
        cs_falls++;
      end
      if (!adc_if.ADC_CS_N) begin
        width++;
        if (!prev_dclk && adc_if.ADC_DCLK) begin
          if (rises < 8) m_cmd = {m_cmd[6:0], adc_if.ADC_DIN};
          if (rises == 7) begin
            if (m_cmd == CMD_X) m_sample = (xq.size() > 0) ? xq.pop_front() : 12'h000;
            else                m_sample = (yq.size() > 0) ? yq.pop_front() : 12'h000;
          end
          rises++;
        end
        if (prev_dclk && !adc_if.ADC_DCLK)
          adc_if.ADC_DOUT = (rises >= DATA_FIRST && rises < DATA_FIRST + DATA_BITS)
                            ? m_sample[DATA_FIRST + DATA_BITS - 1 - rises] : 1'b0;
      end
      if (!prev_cs && adc_if.ADC_CS_N) begin
        adc_if.ADC_DOUT = 1'b0;
        if (frame_chk && !rst) begin
          chk("cs_low_width", width, C_CS_LOW);
          if (cmd_q.size() == 0) begin
            n_checks++;
            $display("FAIL frame_cmd: got unexpected frame cmd %0h expected none", m_cmd);
          end else begin
            chk("frame_cmd", m_cmd, cmd_q.pop_front());
          end
        end
      end
      prev_cs   = adc_if.ADC_CS_N;
      prev_dclk = adc_if.ADC_DCLK;
    end
  end

  // Scoreboard monitor: every Coord_En strobe pops one expected pair.
  initial begin
    logic [23:0] p;
    forever begin
      @(negedge clk);
      if (coord_en === 1'b1) begin
        coord_cnt++;
        strobe_t.push_back(cyc);
        if (pair_q.size() == 0) begin
          n_checks++;
          $display("FAIL coord_unexpected: got X=%0h Y=%0h expected no strobe", x_coord, y_coord);
        end else begin
          p = pair_q.pop_front();
          chk("x_coord", x_coord, p[23:12]);
          chk("y_coord", y_coord, p[11:0]);
        end
        chk("touch_en_at_strobe", touch_en, 1);
      end
    end
  end

  initial begin
    int k;
    int base;
    int d0;
    adc_if.PENIRQ_N = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_cs_n", adc_if.ADC_CS_N, 1);
    chk("rst_dclk", adc_if.ADC_DCLK, 0);
    chk("rst_din", adc_if.ADC_DIN, 0);
    chk("rst_touch_en", touch_en, 0);
    chk("rst_coord_en", coord_en, 0);
    chk("rst_x", x_coord, 0);
    chk("rst_y", y_coord, 0);

    // Press one cycle shorter than the debounce window.
    @(negedge clk) adc_if.PENIRQ_N = 1'b0;
    repeat (C_DEB - 1) @(negedge clk);
    adc_if.PENIRQ_N = 1'b1;
    repeat (60) @(negedge clk);
    chk("short_press_cs", cs_falls, 0);
    chk("short_press_touch", touch_en, 0);

    // Continuous press: first pair, three incrementing pairs, then a released pair.
    push_frames(12'hA5C, 12'hA5C, 12'h3E1, 12'h3E1, 1, 12'hA5C, 12'h3E1);
    push_frames(12'h123, 12'h123, 12'h456, 12'h456, 1, 12'h123, 12'h456);
    push_frames(12'h124, 12'h124, 12'h457, 12'h457, 1, 12'h124, 12'h457);
    push_frames(12'h125, 12'h125, 12'h458, 12'h458, 1, 12'h125, 12'h458);
    push_frames(12'h7FF, 12'h7FF, 12'h800, 12'h800, 0, 12'h000, 12'h000);
    @(negedge clk) adc_if.PENIRQ_N = 1'b0;
    wait_coord(1, 3000);
    chk("touch_en_pressed", touch_en, 1);
    wait_coord(4, 5000);
    if (strobe_t.size() >= 4) begin
      d0 = strobe_t[1] - strobe_t[0];
      chk("spacing_min", 32'(d0 >= 2 * C_CS_LOW + C_GAP), 1);
      chk("spacing_2", strobe_t[2] - strobe_t[1], d0);
      chk("spacing_3", strobe_t[3] - strobe_t[2], d0);
    end

    // Release in the middle of a Y conversion.
    k = 0;
    while (!(adc_if.ADC_CS_N === 1'b0 && m_cmd == CMD_Y && rises >= 10) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_frame_y", 32'(k < 3000), 1);
    adc_if.PENIRQ_N = 1'b1;
    k = 0;
    while (touch_en !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("release_touch_fall", touch_en, 0);
    chk("release_x_hold", x_coord, 12'h125);
    chk("release_y_hold", y_coord, 12'h458);
    chk("release_no_strobe", coord_cnt, 4);
    base = cs_falls;
    repeat (100) @(negedge clk);
    chk("release_idle", cs_falls, base);

    // Reset at DCLK period 12 of a frame.
    frame_chk = 1'b0;
    adc_if.PENIRQ_N = 1'b0;
    k = 0;
    while (!(adc_if.ADC_CS_N === 1'b0 && rises >= 13) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_period_12", 32'(k < 3000), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_cs_n", adc_if.ADC_CS_N, 1);
    chk("abort_dclk", adc_if.ADC_DCLK, 0);
    chk("abort_touch_en", touch_en, 0);
    adc_if.PENIRQ_N = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = cs_falls;
    repeat (100) @(negedge clk);
    chk("abort_no_strobe", coord_cnt, 4);
    chk("abort_x", x_coord, 0);
    chk("abort_y", y_coord, 0);
    chk("abort_idle", cs_falls, base);
    xq.delete();
    yq.delete();
    cmd_q.delete();
    frame_chk = 1'b1;

    // One more pair after recovery (averaged when the feature is built in).
`ifdef TOUCH_AVERAGE_EN
    push_frames(12'h100, 12'h103, 12'h200, 12'h201, 1, 12'h101, 12'h200);
`else
    push_frames(12'h100, 12'h100, 12'h200, 12'h200, 1, 12'h100, 12'h200);
`endif
    @(negedge clk) adc_if.PENIRQ_N = 1'b0;
    wait_coord(5, 3000);
    adc_if.PENIRQ_N = 1'b1;
    push_frames(12'h000, 12'h000, 12'h000, 12'h000, 0, 12'h000, 12'h000);
    k = 0;
    while (touch_en !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("final_touch_fall", touch_en, 0);
`ifdef TOUCH_AVERAGE_EN
    chk("final_x", x_coord, 12'h101);
`else
    chk("final_x", x_coord, 12'h100);
`endif
    chk("final_y", y_coord, 12'h200);
    chk("final_strobes", coord_cnt, 5);
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("pair_q_drained", pair_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
